// File: rtl/shift_regg.sv
// Left-shifting serial-in/parallel-out register with a bit counter that
// raises a registered one-cycle word_valid each time WIDTH bits have been accepted.
module shift_regg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             so,
  output logic             word_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] data;
  logic [CW-1:0]    cnt;
  logic             last_bit;

  // The accepted shift arriving while cnt == LAST completes the current word.
  assign last_bit = (cnt == LAST);

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see pre-edge values; the reset is synchronous and wins over shift.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data       <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= shift && last_bit;
      if (shift) begin
        data <= {data[WIDTH-2:0], si};
        cnt  <= last_bit ? '0 : cnt + CW'(1);
      end
    end
  end

  assign po = data;
  assign so = data[WIDTH-1];

endmodule

// File: tb/tb_shift_regg.sv
// Scoreboarded bench for shift_regg: driver pushes expected outputs from a
// bit-history model, a monitor pops and compares after every rising edge.
module tb_shift_regg;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] po;
    logic             so;
    logic             wv;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, shift, si;
  logic [WIDTH-1:0] po;
  logic             so, word_valid;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  int   pulse_cycles[$];

  // Reference model state: bits received since the last reset, plus a count.
  bit   hist[$];
  int   accepted = 0;

  shift_regg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .shift(shift), .si(si),
    .po(po), .so(so), .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Apply one cycle of stimulus and push what the outputs must be after the edge.
  task automatic step(input logic r, input logic s, input logic d);
    exp_t e;
    int   n;
    @(negedge clk);
    rst_n = r; shift = s; si = d;
    e.wv = 1'b0;
    if (!r) begin
      hist.delete();
      accepted = 0;
    end else if (s) begin
      hist.push_back(d);
      if (hist.size() > WIDTH) void'(hist.pop_front());
      accepted++;
      e.wv = (accepted % WIDTH == 0);
    end
    n = hist.size();
    e.po = '0;
    for (int i = 0; i < WIDTH; i++)
      if (i < n) e.po[i] = hist[n - 1 - i];
    e.so = e.po[WIDTH-1];
    sb_q.push_back(e);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are meaningful every cycle once an expectation exists.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (word_valid === 1'b1) pulse_cycles.push_back(cyc);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("po", 32'(po), 32'(e.po));
      check("so", 32'(so), 32'(e.so));
      check("word_valid", 32'(word_valid), 32'(e.wv));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] word;
    logic [15:0]      stream;
    logic [WIDTH-1:0] tail;
    int               wait_cnt;

    rst_n = 1'b1; shift = 1'b0; si = 1'b0;

    // Reset has priority over a simultaneous shift of a 1.
    step(1'b0, 1'b1, 1'b1);
    after_edge();
    check("reset_po", 32'(po), 32'h0);
    check("reset_wv", 32'(word_valid), 32'h0);

    // Word assembly: 1,0,1,1,0,0,1,0 first bit first -> 0xB2.
    word = 8'b1011_0010;
    pulse_cycles.delete();
    for (int i = WIDTH - 1; i >= 0; i--) step(1'b1, 1'b1, word[i]);
    after_edge();
    check("word_po", 32'(po), 32'hB2);
    check("word_so", 32'(so), 32'h1);
    check("word_pulses", 32'(pulse_cycles.size()), 32'd1);

    // Hold with si toggling.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'(i));
    after_edge();
    check("hold_po", 32'(po), 32'hB2);
    check("hold_pulses", 32'(pulse_cycles.size()), 32'd1);

    // Gapped shifting of ones from a cleared register.
    step(1'b0, 1'b0, 1'b0);
    pulse_cycles.delete();
    for (int i = 0; i < WIDTH; i++) begin
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0);
    end
    after_edge();
    check("gap_po", 32'(po), 32'hFF);
    check("gap_pulses", 32'(pulse_cycles.size()), 32'd1);

    // Reset in the middle of a word discards the partial word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    pulse_cycles.delete();
    step(1'b0, 1'b0, 1'b0);
    after_edge();
    check("midreset_po", 32'(po), 32'h0);
    for (int i = 0; i < WIDTH; i++) step(1'b1, 1'b1, 1'b0);
    after_edge();
    check("midreset_pulses", 32'(pulse_cycles.size()), 32'd1);

    // Streaming: 16 consecutive shifts give two pulses 8 cycles apart.
    stream = 16'($urandom);
    pulse_cycles.delete();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, stream[15 - i]);
    after_edge();
    tail = stream[7:0];
    check("stream_pulses", 32'(pulse_cycles.size()), 32'd2);
    if (pulse_cycles.size() == 2)
      check("stream_spacing", 32'(pulse_cycles[1] - pulse_cycles[0]), 32'd8);
    check("stream_po", 32'(po), 32'(tail));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 24) != 0), 1'($urandom), 1'($urandom));
    step(1'b1, 1'b0, 1'b0);

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_regg.md
SHIFT_REGG -- requirements
Module: shift_regg

Interface
REQ-001 Parameter: WIDTH, 8, register length in bits; WIDTH SHALL be at least 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port: rst_n  input  1  reset; synchronous and active-low, sampled on the clk rising edge.
REQ-004 Port: shift  input  1  shift enable; high means shift one bit on this edge.
REQ-005 Port: si  input  1  serial data in.
REQ-006 Port: po  output  WIDTH  parallel output; the full register contents.
REQ-007 Port: so  output  1  serial out; the bit that the next shift pushes out (register MSB).
REQ-008 Port: word_valid  output  1  registered one-cycle pulse marking that a complete WIDTH-bit word has been assembled.

Function
REQ-009 On a clk rising edge with rst_n=1 and shift=1, the register SHALL load {reg[WIDTH-2:0], si}, with si entering at bit 0 and earlier bits moving toward the MSB.
REQ-010 On a clk rising edge with rst_n=1 and shift=0, the register, the bit counter and the word state SHALL hold; the value of si is ignored.
REQ-011 po SHALL equal the register combinationally; it SHALL add no extra latency beyond the shifting edge.
REQ-012 so SHALL equal reg[WIDTH-1] combinationally, i.e. the first-received bit once WIDTH bits are in.
REQ-013 An internal counter of width ceil(log2(WIDTH)) SHALL count accepted shifts (shift=1 edges) from 0 to WIDTH-1, then wrap to 0 on the next accepted shift.
REQ-014 word_valid SHALL be driven high for exactly one clock cycle, starting at the edge of the accepted shift that wraps the counter from WIDTH-1 to 0 (the WIDTH-th bit of a word); in every other cycle it SHALL be low.
REQ-015 Cycles with shift=0 between accepted shifts SHALL NOT reset or advance the counter; words may be assembled with gaps.
REQ-016 Back-to-back words: continuous shifting SHALL produce a word_valid pulse every WIDTH cycles, with no dead cycle.
REQ-017 An unknown (X) si SHALL propagate into the register unchanged; no filtering or checks are performed.
REQ-018 There SHALL be no parallel-load and no direction control; shifting is left-only.

Reset
REQ-019 When rst_n=0 at a clk rising edge: register <= 0, counter <= 0, word_valid <= 0; so and po therefore read 0.
REQ-020 Reset SHALL take priority over shift; a shift requested in the same cycle is discarded.
REQ-021 A reset in the middle of a word SHALL discard the partial word; the next word_valid SHALL require WIDTH new accepted shifts.
REQ-022 Before the first reset, the outputs are undefined; the bench SHALL apply reset before checking any output.

Verification (WIDTH=8)
REQ-023 Reset priority: rst_n=0 for 1 edge with shift=1 and si=1 -> po=0x00, so=0, word_valid=0.
REQ-024 Word assembly: shift=1 continuously with si sequence 1,0,1,1,0,0,1,0 (first bit first) -> po=0xB2 after the 8th edge, so=1, word_valid high for that one cycle only.
REQ-025 Hold: after the word-assembly scenario, shift=0 for 5 cycles with si toggling -> po remains 0xB2, word_valid stays 0.
REQ-026 Gapped shifting: 8 accepted shifts of si=1, each followed by a shift=0 idle cycle -> po steps 0x01, 0x03 ... 0xFF, and word_valid pulses once, on the 8th accepted shift.
REQ-027 Reset mid-word: 3 shifts of si=1, then rst_n=0 for 1 edge, then 8 shifts of si=0 -> po=0x00 immediately after the reset, and word_valid pulses only on the 8th shift after reset.
REQ-028 Streaming: 16 consecutive shifts -> exactly 2 word_valid pulses, 8 cycles apart, and po after edge 16 equals the last 8 si bits.
